// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and instruction fetch front end with a 2-entry output buffer
module fetch_unit #(
    parameter int              PC_W     = 12,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    logic [PC_W-1:0]    fpc;
    logic               inflight;
    logic [PC_W-1:0]    inflight_pc;
    logic [1:0]         cnt;
    logic               head;
    logic               tail;
    logic [INSTR_W-1:0] ent_instr [2];
    logic [PC_W-1:0]    ent_pc    [2];

    logic               pop;
    logic               push;
    logic               issue;
    logic [2:0]         occ;

    assign out_valid = (cnt != 2'd0);
    assign out_instr = ent_instr[head];
    assign out_pc    = ent_pc[head];

    assign pop       = out_valid & out_ready;
    assign push      = inflight & ~redirect;
    assign occ       = {1'b0, cnt} + {2'b00, inflight};
    // Reserving a slot for every in-flight read keeps cnt + inflight <= 2.
    assign issue     = redirect | (occ < 3'd2) | pop;
    assign imem_addr = redirect ? redirect_pc : fpc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc          <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc  <= '0;
            cnt          <= 2'd0;
            head         <= 1'b0;
            tail         <= 1'b0;
            ent_instr[0] <= '0;
            ent_instr[1] <= '0;
            ent_pc[0]    <= '0;
            ent_pc[1]    <= '0;
        end else begin
            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= imem_addr;
                fpc         <= imem_addr + PC_W'(1);
            end else begin
                inflight    <= 1'b0;
            end

            // A redirect discards buffered and in-flight wrong-path fetches.
            if (redirect) begin
                cnt  <= 2'd0;
                head <= 1'b0;
                tail <= 1'b0;
            end else begin
                if (push) begin
                    ent_instr[tail] <= imem_rdata;
                    ent_pc[tail]    <= inflight_pc;
                    tail            <= ~tail;
                end
                if (pop) begin
                    head <= ~head;
                end
                case ({push, pop})
                    2'b10:   cnt <= cnt + 2'd1;
                    2'b01:   cnt <= cnt - 2'd1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against a queue model
module tb_fetch_unit;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               redirect = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    int checks = 0;
    int failures = 0;

    // Model: pcs sitting in the buffer in delivery order, plus the read issued last cycle.
    logic [PC_W-1:0] q[$];
    logic            pend_v = 1'b0;
    logic [PC_W-1:0] pend_pc = '0;
    logic [PC_W-1:0] mpc = '0;

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC('0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] rom(input logic [PC_W-1:0] a);
        return 32'h100 + {20'h0, a};
    endfunction

    always @(posedge clk) imem_rdata <= rom(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: check outputs, apply inputs, advance the model, move to next negedge.
    task automatic step(input logic r, input logic [PC_W-1:0] rpc, input logic rdy);
        logic            ev;
        logic            pop;
        logic            issue;
        logic [PC_W-1:0] ea;
        int              occ;
        ev = (q.size() != 0);
        chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
        if (ev) begin
            chk("out_pc", {20'b0, out_pc}, {20'b0, q[0]});
            chk("out_instr", out_instr, rom(q[0]));
        end
        redirect = r;
        redirect_pc = rpc;
        out_ready = rdy;
        #1;
        ea = r ? rpc : mpc;
        chk("imem_addr", {20'b0, imem_addr}, {20'b0, ea});
        pop = ev && rdy;
        occ = q.size() + (pend_v ? 1 : 0);
        issue = r || (occ < 2) || pop;
        if (r) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (pend_v) q.push_back(pend_pc);
        end
        if (q.size() > 2) chk("overflow", q.size(), 2);
        if (issue) begin
            pend_v = 1'b1;
            pend_pc = ea;
            mpc = ea + 12'd1;
        end else begin
            pend_v = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run_until_head(input logic [PC_W-1:0] target, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (q.size() != 0 && q[0] == target) begin
                found = 1'b1;
                break;
            end
            step(1'b0, '0, 1'b1);
        end
        chk(tag, {31'b0, found}, 32'd1);
    endtask

    task automatic model_reset();
        q.delete();
        pend_v = 1'b0;
        mpc = '0;
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", {20'b0, out_pc}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_addr", {20'b0, imem_addr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Stream, then a five-cycle stall at pc 4.
        run_until_head(12'd4, "seek_pc4");
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
        chk("stall_hold_pc", {20'b0, out_pc}, 32'd4);

        // Redirect while pc 7 is being popped.
        run_until_head(12'd7, "seek_pc7");
        step(1'b1, 12'h080, 1'b1);
        chk("redir_bubble", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // Redirect during a full-buffer stall.
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        step(1'b1, 12'h010, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

        // Wrap around the top of the address space.
        step(1'b1, 12'hFFE, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);

        // Back-to-back redirects.
        step(1'b1, 12'h200, 1'b1);
        step(1'b1, 12'h300, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) == 0), 12'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset between edges mid-stream.
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        redirect = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_addr", {20'b0, imem_addr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end stage directly upstream of the instruction decoder.
- Owns the 12-bit word-address PC and drives the synchronous instruction ROM, which has 1-cycle read latency.
- Delivers {instr, pc} pairs to decode through a valid/ready handshake, using a 2-entry output buffer.
- Accepts redirects (taken branch, jal, jalr) from execute. Flushes wrong-path fetches on redirect.

Parameters:
- PC_W, 12, PC / instruction-memory word-address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- redirect  input  1  execute resolved a control transfer; restart fetch at redirect_pc
- redirect_pc  input  PC_W  target word address (branch_addr / jal_addr / jalr_addr)
- imem_addr  output  PC_W  ROM read address; data returns on imem_rdata next cycle
- imem_rdata  input  INSTR_W  ROM read data for the address presented in the previous cycle
- out_valid  output  1  out_instr/out_pc hold a valid instruction
- out_ready  input  1  decode accepts the current instruction
- out_instr  output  INSTR_W  instruction to decoder
- out_pc  output  PC_W  word address of out_instr

Behaviour:
- State:
  - fpc: next fetch PC.
  - inflight bit plus inflight_pc: a ROM read whose data arrives this cycle.
  - Buffer: 2 entries of {instr, pc}, occupancy cnt in 0..2, head/tail pointers.
- Reset (async, rst_n=0) values:
  - fpc=RESET_PC, inflight=0, cnt=0.
  - out_valid=0, out_instr=0, out_pc=0.
- Handshake:
  - pop = out_valid & out_ready.
  - out_valid = (cnt != 0). Outputs come from the buffer head and are registered; there is no combinational path from imem_rdata to the outputs.
  - While out_valid=1 and out_ready=0, out_instr and out_pc hold stable.
- Issue rule:
  - issue = redirect | ((cnt + inflight) < 2) | pop.
  - Invariant: cnt + inflight <= 2 at all times. The buffer never overflows.
- imem_addr:
  - imem_addr = redirect ? redirect_pc : fpc. This is combinational, so the redirect target issues in the same cycle.
  - The ROM reads every cycle; an address presented while issue=0 is ignored. On no-issue cycles fpc holds and imem_addr stays at fpc.
- On issue:
  - inflight <= 1, inflight_pc <= imem_addr.
  - fpc <= imem_addr + 1, modulo 2^PC_W, so 4095 wraps to 0.
- When not issuing: inflight <= 0.
- Capture: when inflight=1 and redirect=0, push {imem_rdata, inflight_pc} into the buffer tail.
  - Push and pop in the same cycle: cnt is unchanged.
- Latency: an address issued in cycle t is captured at the end of t+1, giving out_valid in t+2.
  - Steady stream with out_ready=1: one instruction per cycle, PCs consecutive.
- Redirect in cycle t, which has priority over everything:
  - cnt <= 0. The captured in-flight data is discarded.
  - A pop in the same cycle counts as consumed by decode.
  - Target issues in t and appears at out_valid in t+2 with out_pc=redirect_pc.
  - out_valid=0 in t+1.
  - Redirect while out_ready=0 also flushes.
  - Back-to-back redirects: the later one wins, and each flushes the previous one's fetch.
- Reset mid-operation: all state clears immediately, asynchronously.
  - The first clock edge after rst_n rises issues RESET_PC.
  - First out_valid occurs 2 cycles after that edge.
- A ROM with latency other than 1 is out of scope.

Test Plan:
- Stream: RESET_PC=0, ROM[i]=i+0x100, out_ready=1 -> out_valid rises 2 cycles after first issue; out_pc 0,1,2,3… each cycle; out_instr = 0x100,0x101,…
- Stall: hold out_ready=0 for 5 cycles mid-stream at out_pc=4 -> cnt reaches 2, fetch stops. out_pc=4 stays stable. On release, outputs are 4,5,6,… with no drop or duplicate.
- Redirect: redirect=1, redirect_pc=0x080 while out_pc=7 is popped -> imem_addr=0x080 in same cycle; out_valid=0 next cycle; then out_pc 0x080,0x081,…; PCs 8/9 never appear.
- Redirect during stall: cnt=2, out_ready=0, redirect to 0x010 -> buffer flushed; out_pc=0x010 two cycles later once out_ready=1.
- Wrap: redirect_pc=0xFFE -> out_pc sequence 0xFFE,0xFFF,0x000,0x001.
- Async reset mid-stream: drop rst_n between clock edges -> out_valid=0 and fpc=RESET_PC immediately. After release, stream restarts at out_pc=RESET_PC.
